// File: rtl/bresenham_line_engine.sv
// Bresenham line rasteriser covering all eight octants.
// Endpoints are latched on start, normalised in SETUP, then streamed one pixel per handshake.
module bresenham_line_engine #(
    parameter int WIDTH = 13
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] x0,
    input  logic signed [WIDTH-1:0] y0,
    input  logic signed [WIDTH-1:0] x1,
    input  logic signed [WIDTH-1:0] y1,
    output logic                    busy,
    output logic                    pix_valid,
    input  logic                    pix_ready,
    output logic signed [WIDTH-1:0] pix_x,
    output logic signed [WIDTH-1:0] pix_y,
    output logic                    pix_last,
    output logic                    done
);
    localparam int EW = WIDTH + 2;

    typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} state_t;

    function automatic logic signed [EW-1:0] sext(input logic signed [WIDTH-1:0] v);
        return {{(EW-WIDTH){v[WIDTH-1]}}, v};
    endfunction

    function automatic logic signed [EW-1:0] sabs(input logic signed [EW-1:0] v);
        return (v < 0) ? -v : v;
    endfunction

    state_t                  state_q, state_d;
    logic signed [WIDTH-1:0] ex0_q, ey0_q, ex1_q, ey1_q;
    logic signed [WIDTH-1:0] ex0_d, ey0_d, ex1_d, ey1_d;
    logic signed [WIDTH-1:0] x_q, y_q, xend_q, x_d, y_d, xend_d;
    logic signed [EW-1:0]    dx_q, dy_q, err_q, dx_d, dy_d, err_d;
    logic                    steep_q, yneg_q, steep_d, yneg_d;
    logic                    busy_q, valid_q, last_q, done_q;
    logic                    busy_d, valid_d, last_d, done_d;
    logic signed [WIDTH-1:0] px_q, py_q, px_d, py_d;

    logic signed [EW-1:0]    adx, ady, dxs, dys, err_step;
    logic                    steep_s, swap_s;
    logic signed [WIDTH-1:0] a0, b0, a1, b1, pa0, pb0, pa1, pb1;

    always_comb begin
        state_d = state_q;
        ex0_d   = ex0_q;
        ey0_d   = ey0_q;
        ex1_d   = ex1_q;
        ey1_d   = ey1_q;
        x_d     = x_q;
        y_d     = y_q;
        xend_d  = xend_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        err_d   = err_q;
        steep_d = steep_q;
        yneg_d  = yneg_q;

        // Normalise into swapped space: a is the major axis, walked upwards.
        adx      = sabs(sext(ex1_q) - sext(ex0_q));
        ady      = sabs(sext(ey1_q) - sext(ey0_q));
        steep_s  = ady > adx;
        a0       = steep_s ? ey0_q : ex0_q;
        b0       = steep_s ? ex0_q : ey0_q;
        a1       = steep_s ? ey1_q : ex1_q;
        b1       = steep_s ? ex1_q : ey1_q;
        swap_s   = a0 > a1;
        pa0      = swap_s ? a1 : a0;
        pb0      = swap_s ? b1 : b0;
        pa1      = swap_s ? a0 : a1;
        pb1      = swap_s ? b0 : b1;
        dxs      = sext(pa1) - sext(pa0);
        dys      = sext(pb1) - sext(pb0);
        err_step = err_q - dy_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    ex0_d   = x0;
                    ey0_d   = y0;
                    ex1_d   = x1;
                    ey1_d   = y1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                steep_d = steep_s;
                x_d     = pa0;
                y_d     = pb0;
                xend_d  = pa1;
                dx_d    = dxs;
                dy_d    = sabs(dys);
                yneg_d  = dys < 0;
                err_d   = dxs >>> 1;
                state_d = DRAW;
            end
            DRAW: begin
                if (pix_ready) begin
                    if (x_q == xend_q) begin
                        state_d = DONE;
                    end else begin
                        x_d = x_q + WIDTH'(1);
                        if (err_step < 0) begin
                            err_d = err_step + dx_q;
                            y_d   = yneg_q ? y_q - WIDTH'(1) : y_q + WIDTH'(1);
                        end else begin
                            err_d = err_step;
                        end
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d  = state_d != IDLE;
        valid_d = state_d == DRAW;
        done_d  = state_d == DONE;
        last_d  = (state_d == DRAW) && (x_d == xend_d);
        px_d    = steep_d ? y_d : x_d;
        py_d    = steep_d ? x_d : y_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ex0_q   <= '0;
            ey0_q   <= '0;
            ex1_q   <= '0;
            ey1_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            xend_q  <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            err_q   <= '0;
            steep_q <= 1'b0;
            yneg_q  <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            px_q    <= '0;
            py_q    <= '0;
        end else begin
            state_q <= state_d;
            ex0_q   <= ex0_d;
            ey0_q   <= ey0_d;
            ex1_q   <= ex1_d;
            ey1_q   <= ey1_d;
            x_q     <= x_d;
            y_q     <= y_d;
            xend_q  <= xend_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            err_q   <= err_d;
            steep_q <= steep_d;
            yneg_q  <= yneg_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
            px_q    <= px_d;
            py_q    <= py_d;
        end
    end

    assign busy      = busy_q;
    assign pix_valid = valid_q;
    assign pix_last  = last_q;
    assign done      = done_q;
    assign pix_x     = px_q;
    assign pix_y     = py_q;
endmodule

// File: doc/bresenham_line_engine.md
# bresenham_line_engine

Self-contained, parametrised Bresenham line rasteriser for the line drawing core. It takes two endpoints, resolves octant, slope and direction internally, and streams one pixel coordinate per cycle through a valid/ready handshake to the frame-buffer writer. It supersedes the external-controller error/y datapath and covers all eight octants, including steep lines, reversed endpoints and negative y direction.

## Interface
- WIDTH, 13, coordinate width in bits, signed two's complement.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request a line; sampled only in IDLE.
- x0, y0, x1, y1  input  WIDTH each  signed endpoints; sampled on the accepted start edge.
- busy  output  1  high from the cycle after an accepted start until DONE exits.
- pix_valid  output  1  pix_x/pix_y/pix_last hold a valid pixel.
- pix_ready  input  1  consumer accepts the pixel; handshake when pix_valid && pix_ready.
- pix_x, pix_y  output  WIDTH each  pixel coordinate, in original (unswapped) axes.
- pix_last  output  1  current pixel is the final pixel of the line.
- done  output  1  one-cycle pulse after the last pixel handshake.

## Operation
- FSM states: IDLE, SETUP, DRAW, DONE.
- IDLE: start=1 latches the endpoints and moves to SETUP. No other input has any effect.
- SETUP (1 cycle):
  - steep = |y1-y0| > |x1-x0|. If steep, swap x and y of both endpoints.
  - If the swapped x0 > x1, exchange the endpoints.
  - Compute dx = x1-x0 (≥0), dy = |y1-y0|, ystep = +1 if y0<y1 else -1, err = dx>>1, x = x0, y = y0.
  - Go to DRAW.
- DRAW:
  - Present pixel (x,y), or (y,x) when steep, with pix_valid=1 and pix_last = (x == x1).
  - On a handshake with pix_last=0: err' = err - dy; if err' < 0 then y += ystep and err' += dx; x += 1.
  - On a handshake with pix_last=1: go to DONE.
- DONE (1 cycle): done=1, pix_valid=0, then IDLE.
- Emission order follows increasing x in swapped space, so a line given right-to-left is emitted left-to-right. The consumer must not depend on endpoint order.
- Arithmetic:
  - Deltas, err and their intermediate sums are WIDTH+2 bits, signed.
  - Sign extension is required; no wrap occurs for any pair of WIDTH-bit endpoints.
  - Coordinates stay WIDTH bits.
- A zero-length line (x0==x1, y0==y1) emits exactly one pixel with pix_last=1.
- Pixel count is always max(|dx|,|dy|)+1.

## Timing
- Reset (rst=0, any state, mid-line included): state IDLE; busy, pix_valid, pix_last and done = 0; pix_x and pix_y = 0; internal registers cleared. The partial line is discarded and nothing further is emitted.
- Start accepted at edge k: busy=1 and state SETUP after edge k; pix_valid=1 after edge k+1.
- Throughput: one pixel per cycle while pix_ready=1. N pixels complete at edge k+N+1, DONE occupies the following cycle, and IDLE is reached after edge k+N+2.
- While pix_valid=1 and pix_ready=0, pix_x, pix_y and pix_last stay stable and internal state does not advance.
- pix_valid never deasserts inside DRAW until the last handshake.
- start asserted in SETUP, DRAW or DONE is ignored and is not queued.
- done and busy are both high in the DONE cycle. start may be asserted again in the first IDLE cycle.
- Outputs are registered or derived from registered state only; there is no combinational path from pix_ready to pix_valid.

## Test plan
- Shallow line, ready held high: (0,0)->(4,2) -> pixels (0,0),(1,0),(2,1),(3,1),(4,2); pix_last only on (4,2); pix_valid at k+2; done pulse at k+7.
- Steep line plus reversed endpoints: (0,0)->(1,3) -> (0,0),(0,1),(1,2),(1,3). Then (4,2)->(0,0) -> the same five pixels as the first scenario, in the same order.
- Negative ystep diagonal: (0,3)->(3,0) -> (0,3),(1,2),(2,1),(3,0). Negative coordinates: (-2,-1)->(1,-1) -> (-2,-1),(-1,-1),(0,-1),(1,-1).
- Backpressure: first scenario with pix_ready toggling 1,0,0,1,0,1... -> identical pixel sequence; outputs held during stalls; no pixel duplicated or dropped. A start pulse mid-line is ignored.
- Zero-length and extreme cases:
  - (5,5)->(5,5) -> single pixel with pix_last=1, done one cycle later.
  - (-4096,-4096)->(4095,4095) -> 8192 pixels ending at (4095,4095), no overflow.
- Reset mid-line: assert rst=0 after the third handshake -> all outputs 0 immediately. After release, a new start for (0,0)->(2,0) -> exactly (0,0),(1,0),(2,0).
